// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, response WAIT_STATES+1 edges after acceptance.
// Backpressure: req_ready is low while a transaction is in flight; the response is held until rsp_ready.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_we,
  output logic [15:0]           txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  req_t                  req_q, req_live, req_cur;
  logic                  enter_resp;
  logic [15:0]           txn_cnt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign req_live  = '{we: req_we, addr: req_addr, wdata: req_wdata};
  // With zero wait states the transaction enters RESP on its acceptance edge, before req_q is loaded.
  assign req_cur   = (state == S_IDLE) ? req_live : req_q;
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);
  assign txn_count = txn_cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WS == 4'd0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
      txn_cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && req_valid) req_q <= req_live;
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_we    <= req_cur.we;
        rsp_rdata <= req_cur.we ? req_cur.wdata : mem[req_cur.addr];
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        txn_cnt   <= txn_cnt + 16'd1;
      end
    end
  end

  // Storage keeps its contents across reset; a store commits only on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && req_cur.we) mem[req_cur.addr] <= req_cur.wdata;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Returns each load's data, or a store acknowledge, over a valid/ready response channel.
- Lets the datapath be exercised against realistic multi-cycle memory instead of the single-cycle array; sits between the processor's address/RD2 outputs and its writeback mux.

Parameters:
- ADDR_WIDTH, 6, word-address width; storage depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- WAIT_STATES, 2, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  processor consumes response.
- rsp_rdata  output  DATA_WIDTH  load data, or written data for a store.
- rsp_we  output  1  echoes req_we of the responded transaction.
- txn_count  output  16  completed transactions, wraps at 65535 -> 0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_we = 0; txn_count = 0; wait counter = 0.
  - Storage array is not reset.
- Three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, latch req_we, req_addr and req_wdata. This edge is the acceptance edge E0.
  - If WAIT_STATES = 0, go directly to RESP. Otherwise go to WAIT with cnt = WAIT_STATES.
- WAIT:
  - req_ready = 0.
  - Each edge: if cnt == 1, go to RESP; else cnt = cnt - 1.
- Entry into RESP (the same edge that leaves IDLE or WAIT):
  - Store: mem[addr] <= wdata and rsp_rdata <= wdata.
  - Load: rsp_rdata <= mem[addr].
  - rsp_we <= latched we; rsp_valid <= 1.
- Latency: rsp_valid rises after edge E0 + WAIT_STATES (1 cycle after acceptance for WAIT_STATES = 0).
- RESP:
  - req_ready = 0.
  - rsp_valid, rsp_rdata and rsp_we are held stable until an edge with rsp_ready = 1.
  - On that edge: rsp_valid <= 0, txn_count <= txn_count + 1 (wrapping), state <= IDLE.
- Back-to-back: earliest next acceptance is the edge after the response handshake, so minimum initiation interval = WAIT_STATES + 2 cycles.
- Requests presented while req_ready = 0 are ignored; the initiator must hold them.
- req_* inputs are ignored outside IDLE; changes after acceptance do not affect the transaction.
- A store becomes visible to a following load (read-after-write).
- rsp_ready while rsp_valid = 0 has no effect.
- Reset mid-operation:
  - A store not yet committed (still in WAIT) is dropped.
  - A store already committed stays in the array.
  - Response and txn_count are cleared.
- WAIT_STATES > 15 is illegal; no check is performed.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> req_ready = 1, rsp_valid = 0, txn_count = 0; after release, no activity with req_valid = 0.
- Store then load, WAIT_STATES = 2: store addr 5 data 0xDEADBEEF accepted at E0 -> rsp_valid after E2, rsp_we = 1, rsp_rdata = 0xDEADBEEF. Load addr 5 -> rsp_rdata = 0xDEADBEEF, rsp_we = 0, txn_count = 2.
- Response backpressure: hold rsp_ready = 0 for 5 cycles during RESP -> rsp_valid and rsp_rdata stable, req_ready = 0, and a new req_valid is not accepted. Raise rsp_ready -> IDLE next cycle, txn_count += 1.
- Zero wait states (WAIT_STATES = 0) with rsp_ready tied high: 4 stores to addr 0..3 (data 0x10..0x13), req_valid held high -> acceptances every 2 cycles. Readback gives 0x10..0x13.
- Reset mid-WAIT: store 0x55 to addr 9 (pre-initialized to 0x0), assert rst_n after E0 and before RESP -> a later load of addr 9 returns 0x0, txn_count = 1 (the load only).
- Counter wrap: force txn_count to 65535 by preceding transactions or a backdoor, complete one load -> txn_count = 0.
